mux8_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 8-to-1 selection datapath. Eight requesters each present a WIDTH-bit data word and a request line. The block grants one requester at a time for a bounded burst, drives the 3-bit select of an internal 8:1 mux, and presents the selected word with a valid flag. It sits in front of any consumer that the eight sources must share.

---
 rtl/mux8_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8:1 selection datapath.
// Grants one requester for a bounded burst and presents its data word with a valid flag.
module mux8_rr_arbiter #(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           req,
   input  logic [8*WIDTH-1:0]   din,
   output logic [2:0]           sel,
   output logic [7:0]           grant,
   output logic                 valid,
   output logic [WIDTH-1:0]     y
);

   localparam int unsigned N     = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 4;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_n;
   logic [IDX_W-1:0]   ptr, ptr_n;
   logic [IDX_W-1:0]   sel_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [N-1:0]       grant_n;
   logic               valid_n;
   logic [IDX_W:0]     pick_ptr;
   logic [IDX_W:0]     pick_next;
   logic               grant_end;

   // First requester at or after 'from' (mod 8); MSB flags that one was found.
   function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] from);
      logic [IDX_W-1:0] idx;
      rr_pick = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = from + IDX_W'(i);
         if (r[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         sel   <= '0;
         grant <= '0;
         valid <= 1'b0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
         sel   <= sel_n;
         grant <= grant_n;
         valid <= valid_n;
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      sel_n     = sel;
      grant_n   = grant;
      pick_ptr  = rr_pick(req, ptr);
      pick_next = rr_pick(req, sel + IDX_W'(1));
      grant_end = !req[sel] || ((cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));

      case (state)
         IDLE: begin
            grant_n = '0;
            if (pick_ptr[IDX_W]) begin
               state_n = GRANT;
               sel_n   = pick_ptr[IDX_W-1:0];
               grant_n = N'(1) << pick_ptr[IDX_W-1:0];
               cnt_n   = '0;
            end
         end
         GRANT: begin
            if (grant_end) begin
               // Rotate past the finishing owner and hand over in the same cycle.
               ptr_n = sel + IDX_W'(1);
               cnt_n = '0;
               if (pick_next[IDX_W]) begin
                  sel_n   = pick_next[IDX_W-1:0];
                  grant_n = N'(1) << pick_next[IDX_W-1:0];
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase

      valid_n = |grant_n;
   end

   always_comb begin
      y = '0;
      if (valid) y = din[int'(sel)*WIDTH +: WIDTH];
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a behavioural owner/pointer model predicts
// grant, sel and valid per edge; a negedge monitor compares them and y.
module tb_mux8_rr_arbiter;

   localparam int unsigned WIDTH     = 3;
   localparam int unsigned MAX_BURST = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [7:0]          req;
   logic [8*WIDTH-1:0]  din;
   logic [2:0]          sel;
   logic [7:0]          grant;
   logic                valid;
   logic [WIDTH-1:0]    y;

   typedef struct {
      logic [7:0] grant;
      logic [2:0] sel;
      logic       valid;
   } exp_t;

   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   // Reference model state: who owns the grant, transfers so far, search start.
   int owner    = -1;
   int xfers    = 0;
   int start    = 0;
   int last_sel = 0;

   mux8_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .din   (din),
      .sel   (sel),
      .grant (grant),
      .valid (valid),
      .y     (y)
   );

   always #5 clk = ~clk;

   function automatic int search(input logic [7:0] r, input int from);
      for (int i = 0; i < 8; i++) begin
         if (r[(from + i) % 8]) return (from + i) % 8;
      end
      return -1;
   endfunction

   // Model: predict the state visible after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      int   k;
      if (rst) begin
         owner = -1; xfers = 0; start = 0; last_sel = 0;
      end else if (owner < 0) begin
         k = search(req, start);
         if (k >= 0) begin
            owner = k; xfers = 0; last_sel = k;
         end
      end else begin
         if (req[owner]) xfers++;
         if (!req[owner] || xfers == int'(MAX_BURST)) begin
            start = (owner + 1) % 8;
            k = search(req, start);
            if (k >= 0) begin
               owner = k; xfers = 0; last_sel = k;
            end else begin
               owner = -1; xfers = 0;
            end
         end
      end
      e.grant = (owner >= 0) ? 8'(1 << owner) : 8'h00;
      e.sel   = 3'(last_sel);
      e.valid = (owner >= 0);
      exp_q.push_back(e);
   end

   // Monitor: compare on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t             e;
      logic [WIDTH-1:0] y_exp;
      logic [8*WIDTH-1:0] shifted;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         shifted = din >> (int'(e.sel) * WIDTH);
         y_exp   = e.valid ? shifted[WIDTH-1:0] : '0;
         checks++;
         if (grant !== e.grant) begin
            errors++;
            $display("FAIL grant t=%0t got=%h want=%h", $time, grant, e.grant);
         end
         checks++;
         if (sel !== e.sel) begin
            errors++;
            $display("FAIL sel t=%0t got=%0d want=%0d", $time, sel, e.sel);
         end
         checks++;
         if (valid !== e.valid) begin
            errors++;
            $display("FAIL valid t=%0t got=%b want=%b", $time, valid, e.valid);
         end
         checks++;
         if (y !== y_exp) begin
            errors++;
            $display("FAIL y t=%0t got=%h want=%h", $time, y, y_exp);
         end
      end
   end

   function automatic logic [8*WIDTH-1:0] index_din();
      logic [8*WIDTH-1:0] d;
      d = '0;
      for (int k = 0; k < 8; k++) d[k*WIDTH +: WIDTH] = WIDTH'(k);
      return d;
   endfunction

   task automatic drive(input logic r, input logic [7:0] q, input int n);
      rst = r;
      req = q;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 8'h00;
      din = index_din();

      // Reset with all requesting, then first grant from slot 0.
      drive(1'b1, 8'hFF, 2);
      drive(1'b0, 8'hFF, 3);
      drive(1'b0, 8'h00, 2);

      // Sole requester across several burst boundaries.
      drive(1'b0, 8'h08, 12);
      drive(1'b0, 8'h00, 2);

      // Full rotation with everyone requesting.
      drive(1'b1, 8'h00, 1);
      drive(1'b0, 8'hFF, 8 * MAX_BURST + 6);
      drive(1'b0, 8'h00, 2);

      // Early release handing over to requester 5.
      drive(1'b1, 8'h00, 1);
      drive(1'b0, 8'h21, 3);
      drive(1'b0, 8'h20, 3);
      drive(1'b0, 8'h00, 2);

      // Pointer fairness around the wrap.
      drive(1'b0, 8'h40, 2);
      drive(1'b0, 8'h01, 2);
      drive(1'b0, 8'h81, 3);
      drive(1'b0, 8'h00, 2);

      // Reset mid-burst, then restart from slot 0.
      drive(1'b0, 8'h10, 2);
      drive(1'b1, 8'h10, 1);
      drive(1'b0, 8'h11, 3);
      drive(1'b0, 8'h00, 2);

      // Randomized requests, data and occasional reset.
      for (int i = 0; i < 150; i++) begin
         logic [7:0] q;
         logic       r;
         int         hold;
         q    = 8'($urandom) & 8'($urandom);
         r    = ($urandom_range(0, 49) == 0);
         hold = $urandom_range(1, 6);
         din  = (8*WIDTH)'($urandom);
         drive(r, q, hold);
      end
      drive(1'b0, 8'h00, 2);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() > 2) begin
         errors++;
         $display("FAIL drain got=%0d want<=2", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
